// File: rtl/fft_ram_reader.sv
// fft_ram_reader: Avalon-MM read master that drains FFT result words from the
// second RAM port and streams them as signed re/im pairs over valid/ready.
// Reads are throttled by a credit check (inflight + FIFO count < depth), so a
// downstream stall never overflows the FIFO, whatever the RAM latency.
module fft_ram_reader #(
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        start,
  input  logic [10:0] base_addr,
  input  logic [11:0] length,
  output logic        busy,
  output logic        done,
  output logic [10:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_clken,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_re,
  output logic [15:0] out_im,
  output logic [10:0] out_index,
  output logic        out_last
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state, state_n;

  logic [10:0] base_q;
  logic [11:0] len_q;
  logic [11:0] issued;
  logic [11:0] out_cnt;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [READ_LATENCY:1] vld_q;
  logic [READ_LATENCY:0] vld_pipe;

  logic accept, strobe, credit_ok, push, pop, head_last;

  // Read returns line up with mem_readdata once the strobe has walked the pipe
  assign vld_pipe  = {vld_q, strobe};
  assign push      = vld_pipe[READ_LATENCY];
  assign pop       = out_valid & out_ready;
  assign accept    = (state == S_IDLE) & start;
  // A same-cycle pop is not credited; this keeps the check purely registered
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH);
  assign head_last = (out_cnt == len_q - 12'd1);

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= S_IDLE;
    else             state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = (length == 12'd0) ? S_DONE : S_READ;
      S_READ:  if (strobe && (issued == len_q - 12'd1)) state_n = S_DRAIN;
      S_DRAIN: if (pop && head_last) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM outputs: status flags and the read strobe
  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    strobe = (state == S_READ) & credit_ok;
  end

  assign mem_chipselect = strobe;
  assign mem_address    = base_q + issued[10:0];
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_writedata  = 32'd0;
  assign mem_byteenable = 4'hF;

  // Latch the command and track issued / delivered word counts
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      base_q  <= '0;
      len_q   <= '0;
      issued  <= '0;
      out_cnt <= '0;
    end else if (accept) begin
      base_q  <= base_addr;
      len_q   <= length;
      issued  <= '0;
      out_cnt <= '0;
    end else begin
      if (strobe) issued  <= issued + 12'd1;
      if (pop)    out_cnt <= out_cnt + 12'd1;
    end
  end

  // Strobe valid pipe and inflight count; cleared on reset so stale returns drop
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      vld_q    <= '0;
      inflight <= '0;
    end else begin
      vld_q <= vld_pipe[READ_LATENCY-1:0];
      case ({strobe, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents only matter once the pointers say so
  always_ff @(posedge clk_clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_readdata;
  end

  // Head word is already registered; zero it while empty so idle outputs are clean
  assign out_valid = (fifo_cnt != '0);
  assign out_re    = out_valid ? fifo_mem[rd_ptr][31:16] : 16'd0;
  assign out_im    = out_valid ? fifo_mem[rd_ptr][15:0]  : 16'd0;
  assign out_index = out_cnt[10:0];
  assign out_last  = out_valid & head_last;

endmodule

// File: tb/tb_fft_ram_reader.sv
// tb_fft_ram_reader: two readers (latency 1 and 2) against RAM models, with a
// word/address scoreboard built from each command's base and length.
module tb_fft_ram_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start [2];
  logic [10:0] base_addr [2];
  logic [11:0] length [2];
  logic        busy [2], done [2], cs [2], clken [2], wr [2];
  logic [31:0] wdata [2], rdata [2];
  logic [3:0]  be [2];
  logic [10:0] addr [2];
  logic        out_valid [2], out_ready [2], out_last [2];
  logic [15:0] out_re [2], out_im [2];
  logic [10:0] out_index [2];

  fft_ram_reader #(.READ_LATENCY(1), .FIFO_DEPTH(4)) u0 (
    .clk_clk(clk), .reset_reset(rst), .start(start[0]), .base_addr(base_addr[0]),
    .length(length[0]), .busy(busy[0]), .done(done[0]), .mem_address(addr[0]),
    .mem_chipselect(cs[0]), .mem_clken(clken[0]), .mem_write(wr[0]),
    .mem_writedata(wdata[0]), .mem_byteenable(be[0]), .mem_readdata(rdata[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_re(out_re[0]),
    .out_im(out_im[0]), .out_index(out_index[0]), .out_last(out_last[0]));

  fft_ram_reader #(.READ_LATENCY(2), .FIFO_DEPTH(4)) u1 (
    .clk_clk(clk), .reset_reset(rst), .start(start[1]), .base_addr(base_addr[1]),
    .length(length[1]), .busy(busy[1]), .done(done[1]), .mem_address(addr[1]),
    .mem_chipselect(cs[1]), .mem_clken(clken[1]), .mem_write(wr[1]),
    .mem_writedata(wdata[1]), .mem_byteenable(be[1]), .mem_readdata(rdata[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_re(out_re[1]),
    .out_im(out_im[1]), .out_index(out_index[1]), .out_last(out_last[1]));

  // RAM contents and read pipes; non-strobed cycles return junk
  function automatic logic [31:0] ram_word(input logic [10:0] a);
    return 32'hAAAA0000 + {21'd0, a};
  endfunction

  logic [31:0] q1 [2], q2 [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      q1[k] <= cs[k] ? ram_word(addr[k]) : 32'hDEADBEEF;
      q2[k] <= q1[k];
    end
  end
  assign rdata[0] = q1[0];
  assign rdata[1] = q2[1];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected words {re,im,index,last} and strobe addresses per instance
  logic [43:0] exp_w [2][4096];
  logic [10:0] exp_a [2][4096];
  int wp [2] = '{0, 0};
  int rp [2] = '{0, 0};
  int awp [2] = '{0, 0};
  int arp [2] = '{0, 0};
  int n_strb [2] = '{0, 0};

  task automatic load(input int k, input int b, input int n);
    logic [10:0] a;
    for (int i = 0; i < n; i++) begin
      a = 11'((b + i) % 2048);
      exp_a[k][awp[k] % 4096] = a;
      awp[k]++;
      exp_w[k][wp[k] % 4096] = {ram_word(a), 11'(i), (i == n - 1)};
      wp[k]++;
    end
  endtask

  // Scoreboard: addresses on strobes, words on handshakes, hold during stalls
  logic        hold [2] = '{1'b0, 1'b0};
  logic [43:0] hold_w [2];
  logic [43:0] cur_w;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) hold[k] = 1'b0;
      else begin
        cur_w = {out_re[k], out_im[k], out_index[k], out_last[k]};
        if (hold[k]) chk("stall_hold", {out_valid[k], cur_w}, {1'b1, hold_w[k]});
        hold[k]   = out_valid[k] & ~out_ready[k];
        hold_w[k] = cur_w;
        if (out_valid[k] && out_ready[k]) begin
          if (rp[k] < wp[k]) begin
            chk("word", cur_w, exp_w[k][rp[k] % 4096]);
            rp[k]++;
          end else chk("extra_word", out_valid[k], 1'b0);
        end
        if (cs[k]) begin
          n_strb[k]++;
          if (arp[k] < awp[k]) begin
            chk("addr", addr[k], exp_a[k][arp[k] % 4096]);
            arp[k]++;
          end else chk("extra_strobe", cs[k], 1'b0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int k, input int b, input int n);
    start[k] = 1'b1;
    base_addr[k] = 11'(b);
    length[k] = 12'(n);
    load(k, b, n);
    step();
    start[k] = 1'b0;
  endtask

  // mode 0: ready held high, mode 1: random ready
  task automatic wait_done(input int k, input int mode, input int bound);
    int c = 0;
    while (done[k] !== 1'b1 && c < bound) begin
      out_ready[k] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      c++;
    end
    chk("done_seen", done[k], 1'b1);
    out_ready[k] = 1'b1;
    step();
    chk("done_pulse", {busy[k], done[k]}, 2'b00);
    chk("all_words", rp[k], wp[k]);
    chk("all_strobes", arp[k], awp[k]);
  endtask

  task automatic chk_rst(input int k);
    chk("rst_ctl", {busy[k], done[k], cs[k], wr[k], out_valid[k], out_last[k]}, 6'd0);
    chk("rst_addr", addr[k], 11'd0);
    chk("rst_const", {clken[k], be[k], wdata[k]}, {1'b1, 4'hF, 32'd0});
    chk("rst_data", {out_re[k], out_im[k], out_index[k]}, 43'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0, b, n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; base_addr[k] = '0; length[k] = '0; out_ready[k] = 1'b1;
    end
    step(); step();
    chk_rst(0);
    chk_rst(1);
    rst = 1'b0;
    step();

    // Cycle-exact basic transfer
    start[0] = 1'b1; base_addr[0] = 11'd0; length[0] = 12'd4; load(0, 0, 4);
    for (int c = 1; c <= 8; c++) begin
      step();
      start[0] = 1'b0;
      chk("t1_cs",    cs[0],        (c >= 1 && c <= 4));
      chk("t1_valid", out_valid[0], (c >= 3 && c <= 6));
      chk("t1_done",  done[0],      (c == 7));
      chk("t1_busy",  busy[0],      (c <= 7));
    end
    chk("t1_words", rp[0], wp[0]);

    // Downstream stall: credits cap outstanding reads at the FIFO depth
    s0 = n_strb[0];
    cmd(0, 0, 12);
    for (int c = 1; c < 13; c++) begin
      out_ready[0] = !(c >= 3);
      step();
    end
    chk("t2_credit", n_strb[0] - s0, 4);
    wait_done(0, 0, 60);

    // Address wrap
    cmd(0, 2046, 4);
    wait_done(0, 1, 100);

    // Zero length
    s0 = n_strb[0];
    start[0] = 1'b1; base_addr[0] = 11'd5; length[0] = 12'd0;
    step();
    start[0] = 1'b0;
    chk("t4_c1", {busy[0], done[0], cs[0], out_valid[0]}, 4'b1100);
    step();
    chk("t4_c2", {busy[0], done[0], cs[0], out_valid[0]}, 4'b0000);
    step();
    chk("t4_nostrb", n_strb[0] - s0, 0);

    // Reset mid-read, then a fresh command
    cmd(0, 0, 16);
    for (int c = 0; c < 5; c++) step();
    rst = 1'b1;
    step();
    chk_rst(0);
    rst = 1'b0;
    wp[0] = rp[0];
    awp[0] = arp[0];
    for (int c = 0; c < 4; c++) step();
    cmd(0, 8, 2);
    wait_done(0, 0, 50);

    // Start while busy is ignored
    cmd(0, 0, 6);
    step();
    start[0] = 1'b1; base_addr[0] = 11'd100; length[0] = 12'd3;
    step();
    start[0] = 1'b0;
    wait_done(0, 0, 60);

    // Latency 2: full-size transfer and random commands under random ready
    cmd(1, $urandom_range(0, 2047), 2048);
    wait_done(1, 1, 20000);
    for (int t = 0; t < 6; t++) begin
      b = $urandom_range(0, 2047);
      n = $urandom_range(1, 40);
      cmd(t % 2, b, n);
      wait_done(t % 2, 1, 400);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_ram_reader.md
# fft_ram_reader

Avalon-MM read master that drains FFT result words from the second port of the dual-port FFT on-chip RAM. It streams them out as signed real/imaginary pairs over a valid/ready interface toward the downstream processing/UART path. A software-visible start/length/base command reads a contiguous, wrap-around address range. An internal FIFO plus a read-credit counter absorb downstream backpressure without losing words already in flight.

## Interface
- READ_LATENCY, 1, RAM read latency in cycles from address/chipselect to valid readdata (1 or 2)
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ READ_LATENCY+2 and a power of two
- clk_clk  in  1  system clock (50 MHz domain)
- reset_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command pulse; ignored while busy=1
- base_addr  in  11  first word address, sampled on accepted start
- length  in  12  number of words, 0..2048, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last word has been accepted downstream
- mem_address  out  11  RAM s2 address
- mem_chipselect  out  1  read strobe; one word per cycle it is high
- mem_clken  out  1  RAM clock enable, constant 1 after reset
- mem_write  out  1  constant 0
- mem_writedata  out  32  constant 0
- mem_byteenable  out  4  constant 4'hF
- mem_readdata  in  32  RAM s2 read data, valid READ_LATENCY cycles after a strobe
- out_valid  out  1  FIFO head holds a word
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_re  out  16  signed, = readdata[31:16] of head word
- out_im  out  16  signed, = readdata[15:0] of head word
- out_index  out  11  offset of head word from base_addr (0..length-1)
- out_last  out  1  head word is word length-1

## Operation
- States: IDLE, READ (issuing strobes), DRAIN (all strobes issued, waiting for FIFO empty), DONE (one cycle).
- IDLE: start=1 with length≠0 → latch base/length, clear issue counter and out counter, go to READ. start=1 with length=0 → go directly to DONE, no strobes.
- READ: assert mem_chipselect with mem_address=(base_addr+issued) mod 2048 when inflight+fifo_count < FIFO_DEPTH. inflight counts strobes whose data has not yet returned; a same-cycle pop is not credited. After strobe length-1 → DRAIN.
- Returned data pushes into the FIFO through a READ_LATENCY-deep valid shift register aligned with mem_readdata. The credit rule guarantees the push never overflows.
- out_index/out_last come from an out counter advanced on each handshake; out_last = (out_counter == length-1).
- DRAIN: leave when last word handshakes → DONE. DONE: done=1, busy=0 next cycle, → IDLE.
- Address arithmetic is 11-bit modulo: base 2046, length 4 reads 2046, 2047, 0, 1.
- start while busy: ignored, no effect on the latched command.
- Reset (any state): return to IDLE and flush the FIFO, inflight pipeline, and counters. Data returning from pre-reset strobes is discarded.

## Timing
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, mem_write=0, mem_writedata=0, mem_byteenable=4'hF, mem_clken=1, out_valid=0, out_re/out_im/out_index=0, out_last=0.
- Start at cycle 0 → first strobe at cycle 1 → readdata at cycle 1+READ_LATENCY, pushed that edge → out_valid at cycle 2+READ_LATENCY.
- With out_ready held 1: one word per cycle sustained; last handshake at cycle 1+READ_LATENCY+length; done pulses the following cycle.
- FIFO push and pop may occur in the same cycle, including on a full FIFO when a pop is present; count is unchanged.
- out_* are registered from the FIFO head. They are stable while out_valid=1 and out_ready=0.

## Test plan
- RAM model with latency 1, words 0xAAAA0000+i; base=0, length=4, ready=1 → chipselect cycles 1-4, out_valid cycles 3-6 with out_re=0xAAAA, out_im=0..3, out_last on index 3, done pulse at cycle 7.
- Same command, ready=0 from cycle 3 for 10 cycles → at most 4 strobes issued and no word lost or duplicated. Words stay in order after ready returns.
- base=2046, length=4 → addresses 2046, 2047, 0, 1; out_index 0..3.
- length=0 → no chipselect, busy high one cycle, done pulse, out_valid never asserted.
- Reset asserted mid-READ of length=16 → next cycle all outputs at reset values. A new start (base=8, length=2) then delivers exactly 2 correct words.
- start pulsed while busy with different base/length → ignored; original transfer completes. READ_LATENCY=2 run, length=2048 with random ready → all 2048 words in order.
